// File: rtl/id_decode_pipe_pkg.sv
// Shared opcode, execute-command and branch encodings for the decode stage,
// plus the opcode-to-control lookup used by id_decode_pipe.
package id_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  typedef enum logic [3:0] {
    EXE_ADD = 4'd0,
    EXE_SUB = 4'd2,
    EXE_AND = 4'd4
  } exe_cmd_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_type_e;

  typedef struct packed {
    exe_cmd_e exe_cmd;
    logic     mem_read;
    logic     mem_write;
    logic     wb_en;
    br_type_e br_type;
    logic     rtype;
    logic     use_src1;
    logic     use_src2;
  } dec_ctrl_t;

  // NOP and every unlisted opcode fall through to all-zero control.
  function automatic dec_ctrl_t decode_op(input logic [5:0] op);
    dec_ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  begin c.exe_cmd = EXE_ADD; c.wb_en = 1'b1; c.rtype = 1'b1; c.use_src1 = 1'b1; c.use_src2 = 1'b1; end
      OP_SUB:  begin c.exe_cmd = EXE_SUB; c.wb_en = 1'b1; c.rtype = 1'b1; c.use_src1 = 1'b1; c.use_src2 = 1'b1; end
      OP_AND:  begin c.exe_cmd = EXE_AND; c.wb_en = 1'b1; c.rtype = 1'b1; c.use_src1 = 1'b1; c.use_src2 = 1'b1; end
      OP_ADDI: begin c.exe_cmd = EXE_ADD; c.wb_en = 1'b1; c.use_src1 = 1'b1; end
      OP_LD:   begin c.exe_cmd = EXE_ADD; c.mem_read = 1'b1; c.wb_en = 1'b1; c.use_src1 = 1'b1; end
      OP_ST:   begin c.exe_cmd = EXE_ADD; c.mem_write = 1'b1; c.use_src1 = 1'b1; c.use_src2 = 1'b1; end
      OP_BEZ:  begin c.br_type = BR_BEZ; c.use_src1 = 1'b1; end
      OP_BNE:  begin c.br_type = BR_BNE; c.use_src1 = 1'b1; c.use_src2 = 1'b1; end
      OP_JMP:  begin c.br_type = BR_JMP; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_decode_pipe_if.sv
// Fetch-side request, stall back-pressure and the registered ID/EXE bundle
// of the decode stage. master = fetch/execute side, slave = decoder.
interface id_decode_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) ();
  logic              in_valid;
  logic [31:0]       instruction;
  logic [XLEN-1:0]   pc;
  logic              flush;
  logic              stall;
  logic              out_valid;
  logic [3:0]        exe_cmd;
  logic              mem_read;
  logic              mem_write;
  logic              wb_en_out;
  logic [1:0]        br_type;
  logic [REG_AW-1:0] src1_addr;
  logic [REG_AW-1:0] src2_addr;
  logic [REG_AW-1:0] dest;
  logic [XLEN-1:0]   val1;
  logic [XLEN-1:0]   val2;
  logic [XLEN-1:0]   st_val;
  logic [XLEN-1:0]   pc_out;

  modport master (
    output in_valid, instruction, pc, flush,
    input  stall, out_valid, exe_cmd, mem_read, mem_write, wb_en_out, br_type,
           src1_addr, src2_addr, dest, val1, val2, st_val, pc_out
  );

  modport slave (
    input  in_valid, instruction, pc, flush,
    output stall, out_valid, exe_cmd, mem_read, mem_write, wb_en_out, br_type,
           src1_addr, src2_addr, dest, val1, val2, st_val, pc_out
  );
endinterface

// File: rtl/id_decode_pipe_hazard_detect.sv
// Combinational RAW hazard detection for the decode stage: load-use only
// when forwarding exists, otherwise any pending write in ID/EXE or EXE/MEM.
module hazard_detect #(
  parameter int REG_AW     = 5,
  parameter int FORWARD_EN = 1
) (
  input  logic              in_valid,
  input  logic              flush,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              use_src1,
  input  logic              use_src2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_wb_en,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  output logic              stall
);
  logic hit1_ex, hit2_ex, hit1_mem, hit2_mem, load_use, raw_any;

  always_comb begin
    hit1_ex  = use_src1 && (src1 != '0) && (src1 == ex_dest);
    hit2_ex  = use_src2 && (src2 != '0) && (src2 == ex_dest);
    hit1_mem = use_src1 && (src1 != '0) && (src1 == mem_dest);
    hit2_mem = use_src2 && (src2 != '0) && (src2 == mem_dest);
    load_use = ex_valid && ex_mem_read && (ex_dest != '0) && (hit1_ex || hit2_ex);
    raw_any  = (ex_wb_en && (hit1_ex || hit2_ex)) || (mem_wb_en && (hit1_mem || hit2_mem));
    // A flush kills the instruction being checked, so it never stalls.
    stall    = in_valid && !flush && ((FORWARD_EN != 0) ? load_use : raw_any);
  end
endmodule

// File: rtl/id_decode_pipe.sv
// Instruction decode stage: field extraction, register file with write-first
// bypass, hazard stall and the registered ID/EXE bundle.
module id_decode_pipe
  import id_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int FORWARD_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  id_decode_pipe_if.slave   dec,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en
);
  localparam int NREGS = 2 ** REG_AW;

  function automatic logic [XLEN-1:0] sext_imm(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

  logic [XLEN-1:0]   regs [NREGS];
  dec_ctrl_t         ctrl;
  logic [REG_AW-1:0] src1_a, src2_a, dest_a;
  logic [XLEN-1:0]   rd1, rd2;
  logic              stall, accept;

  logic              vld_p1, mem_read_p1, mem_write_p1, wb_en_p1;
  logic [3:0]        exe_cmd_p1;
  logic [1:0]        br_type_p1;
  logic [REG_AW-1:0] src1_p1, src2_p1, dest_p1;
  logic [XLEN-1:0]   val1_p1, val2_p1, st_val_p1, pc_p1;

  assign ctrl   = decode_op(dec.instruction[31:26]);
  assign src1_a = REG_AW'(dec.instruction[25:21]);
  assign src2_a = REG_AW'(dec.instruction[20:16]);
  assign dest_a = ctrl.rtype ? REG_AW'(dec.instruction[15:11]) : src2_a;

  // Reads see the value being written back this cycle; r0 is hardwired zero.
  always_comb begin
    if (src1_a == '0)                      rd1 = '0;
    else if (wb_en && (wb_dest == src1_a)) rd1 = wb_data;
    else                                   rd1 = regs[src1_a];
    if (src2_a == '0)                      rd2 = '0;
    else if (wb_en && (wb_dest == src2_a)) rd2 = wb_data;
    else                                   rd2 = regs[src2_a];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_dest != '0)) begin
      regs[wb_dest] <= wb_data;
    end
  end

  hazard_detect #(.REG_AW(REG_AW), .FORWARD_EN(FORWARD_EN)) u_hazard (
    .in_valid    (dec.in_valid),
    .flush       (dec.flush),
    .src1        (src1_a),
    .src2        (src2_a),
    .use_src1    (ctrl.use_src1),
    .use_src2    (ctrl.use_src2),
    .ex_valid    (vld_p1),
    .ex_mem_read (mem_read_p1),
    .ex_wb_en    (wb_en_p1),
    .ex_dest     (dest_p1),
    .mem_wb_en   (mem_wb_en),
    .mem_dest    (mem_dest),
    .stall       (stall)
  );

  assign dec.stall = stall;
  assign accept    = dec.in_valid && !dec.flush && !stall;

  // ---- ID -> ID/EXE (p1): bubble whenever nothing is accepted ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0; exe_cmd_p1 <= '0; mem_read_p1 <= 1'b0; mem_write_p1 <= 1'b0;
      wb_en_p1 <= 1'b0; br_type_p1 <= '0; src1_p1 <= '0; src2_p1 <= '0; dest_p1 <= '0;
      val1_p1 <= '0; val2_p1 <= '0; st_val_p1 <= '0; pc_p1 <= '0;
    end else if (!accept) begin
      vld_p1 <= 1'b0; exe_cmd_p1 <= '0; mem_read_p1 <= 1'b0; mem_write_p1 <= 1'b0;
      wb_en_p1 <= 1'b0; br_type_p1 <= '0; src1_p1 <= '0; src2_p1 <= '0; dest_p1 <= '0;
      val1_p1 <= '0; val2_p1 <= '0; st_val_p1 <= '0; pc_p1 <= '0;
    end else begin
      vld_p1       <= 1'b1;
      exe_cmd_p1   <= ctrl.exe_cmd;
      mem_read_p1  <= ctrl.mem_read;
      mem_write_p1 <= ctrl.mem_write;
      wb_en_p1     <= ctrl.wb_en;
      br_type_p1   <= ctrl.br_type;
      src1_p1      <= src1_a;
      src2_p1      <= src2_a;
      dest_p1      <= dest_a;
      val1_p1      <= rd1;
      val2_p1      <= ctrl.rtype ? rd2 : sext_imm(dec.instruction[15:0]);
      st_val_p1    <= rd2;
      pc_p1        <= dec.pc;
    end
  end

  assign dec.out_valid = vld_p1;
  assign dec.exe_cmd   = exe_cmd_p1;
  assign dec.mem_read  = mem_read_p1;
  assign dec.mem_write = mem_write_p1;
  assign dec.wb_en_out = wb_en_p1;
  assign dec.br_type   = br_type_p1;
  assign dec.src1_addr = src1_p1;
  assign dec.src2_addr = src2_p1;
  assign dec.dest      = dest_p1;
  assign dec.val1      = val1_p1;
  assign dec.val2      = val2_p1;
  assign dec.st_val    = st_val_p1;
  assign dec.pc_out    = pc_p1;
endmodule

// File: tb/tb_id_decode_pipe.sv
// Scoreboard bench for id_decode_pipe: one instance with forwarding, one
// without; directed vectors push expected ID/EXE bundles, a monitor pops them.
module tb_id_decode_pipe;

  typedef struct packed {
    logic [3:0]  exe;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [1:0]  br;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  dd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] st;
    logic [31:0] pc;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [4:0]  mem_dest;
  logic        mem_wb_en;

  int   checks = 0;
  int   failures = 0;
  rec_t q0[$];
  rec_t q1[$];

  always #10 clock = ~clock;

  id_decode_pipe_if #(.XLEN(32), .REG_AW(5)) if0 ();
  id_decode_pipe_if #(.XLEN(32), .REG_AW(5)) if1 ();

  id_decode_pipe #(.XLEN(32), .REG_AW(5), .FORWARD_EN(1)) u0 (
    .clock(clock), .reset(reset), .dec(if0.slave), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_data(wb_data), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en));
  id_decode_pipe #(.XLEN(32), .REG_AW(5), .FORWARD_EN(0)) u1 (
    .clock(clock), .reset(reset), .dec(if1.slave), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_data(wb_data), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en));

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    return {op, a, b, d, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] a, input logic [4:0] d, input logic [15:0] imm);
    return {op, a, d, imm};
  endfunction

  function automatic rec_t mk(input logic [3:0] e, input logic mr, input logic mw, input logic wb,
                              input logic [1:0] br, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] dd, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] st, input logic [31:0] pc);
    return {e, mr, mw, wb, br, s1, s2, dd, v1, v2, st, pc};
  endfunction

  function automatic rec_t act(input int d);
    if (d == 0)
      return {if0.exe_cmd, if0.mem_read, if0.mem_write, if0.wb_en_out, if0.br_type, if0.src1_addr,
              if0.src2_addr, if0.dest, if0.val1, if0.val2, if0.st_val, if0.pc_out};
    return {if1.exe_cmd, if1.mem_read, if1.mem_write, if1.wb_en_out, if1.br_type, if1.src1_addr,
            if1.src2_addr, if1.dest, if1.val1, if1.val2, if1.st_val, if1.pc_out};
  endfunction

  task automatic check(input string nm, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  task automatic check_stall(input int d, input logic e, input string nm);
    check(nm, (d == 0) ? 160'(if0.stall) : 160'(if1.stall), 160'(e));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] ins, input logic [31:0] p, input logic fl);
    if (d == 0) begin
      if0.in_valid = v; if0.instruction = ins; if0.pc = p; if0.flush = fl;
    end else begin
      if1.in_valid = v; if1.instruction = ins; if1.pc = p; if1.flush = fl;
    end
  endtask

  task automatic issue(input int d, input logic [31:0] ins, input logic [31:0] p, input rec_t e);
    drive(d, 1'b1, ins, p, 1'b0);
    #1;
    check_stall(d, 1'b0, "issue_stall");
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    tick();
  endtask

  task automatic wbwrite(input logic [4:0] d, input logic [31:0] v);
    wb_en = 1'b1; wb_dest = d; wb_data = v;
    tick();
    wb_en = 1'b0;
  endtask

  // Monitor: every presented decode result must match the oldest expectation.
  always @(negedge clock) begin
    if (if0.out_valid) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0_unexpected_output actual=%h required=none", act(0));
      end else check("dut0_decode", act(0), q0.pop_front());
    end
    if (if1.out_valid) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_unexpected_output actual=%h required=none", act(1));
      end else check("dut1_decode", act(1), q1.pop_front());
    end
  end

  logic [31:0] tins [7];
  rec_t        texp [7];

  initial begin
    reset = 1'b1; wb_en = 1'b0; wb_dest = '0; wb_data = '0; mem_dest = '0; mem_wb_en = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_state_dut0", {act(0), if0.out_valid}, '0);
    check("reset_state_dut1", {act(1), if1.out_valid}, '0);
    reset = 1'b0;
    tick();

    wbwrite(5'd3, 32'd7);
    wbwrite(5'd1, 32'd5);

    // ADDI r4,r3,-1
    issue(0, itype(6'd32, 5'd3, 5'd4, 16'hFFFF), 32'h100,
          mk(4'd0, 0, 0, 1, 2'd0, 5'd3, 5'd4, 5'd4, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'h100));

    tins[0] = rtype(6'd2, 5'd3, 5'd1, 5'd10);
    texp[0] = mk(4'd2, 0, 0, 1, 2'd0, 5'd3, 5'd1, 5'd10, 32'd7, 32'd5, 32'd5, 32'h110);
    tins[1] = rtype(6'd5, 5'd3, 5'd1, 5'd11);
    texp[1] = mk(4'd4, 0, 0, 1, 2'd0, 5'd3, 5'd1, 5'd11, 32'd7, 32'd5, 32'd5, 32'h114);
    tins[2] = itype(6'd37, 5'd1, 5'd3, 16'd4);
    texp[2] = mk(4'd0, 0, 1, 0, 2'd0, 5'd1, 5'd3, 5'd3, 32'd5, 32'd4, 32'd7, 32'h118);
    tins[3] = itype(6'd40, 5'd3, 5'd0, 16'hFFFE);
    texp[3] = mk(4'd0, 0, 0, 0, 2'd1, 5'd3, 5'd0, 5'd0, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'h11C);
    tins[4] = itype(6'd41, 5'd3, 5'd1, 16'd3);
    texp[4] = mk(4'd0, 0, 0, 0, 2'd2, 5'd3, 5'd1, 5'd1, 32'd7, 32'd3, 32'd5, 32'h120);
    tins[5] = itype(6'd42, 5'd0, 5'd0, 16'h0010);
    texp[5] = mk(4'd0, 0, 0, 0, 2'd3, 5'd0, 5'd0, 5'd0, 32'd0, 32'h10, 32'd0, 32'h124);
    tins[6] = {6'd63, 26'd0};
    texp[6] = mk(4'd0, 0, 0, 0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h128);
    for (int i = 0; i < 7; i++) issue(0, tins[i], texp[i].pc, texp[i]);
    drive(0, 1'b0, '0, '0, 1'b0);
    tick();

    // Load-use: LD r5 then ADD r6,r5,r1 on the forwarding instance
    issue(0, itype(6'd36, 5'd2, 5'd5, 16'd8), 32'h200,
          mk(4'd0, 1, 0, 1, 2'd0, 5'd2, 5'd5, 5'd5, 32'd0, 32'd8, 32'd0, 32'h200));
    drive(0, 1'b1, rtype(6'd1, 5'd5, 5'd1, 5'd6), 32'h204, 1'b0);
    #1;
    check_stall(0, 1'b1, "loaduse_stall");
    tick();
    check("loaduse_bubble", 160'(if0.out_valid), 160'(0));
    check_stall(0, 1'b0, "loaduse_release");
    q0.push_back(mk(4'd0, 0, 0, 1, 2'd0, 5'd5, 5'd1, 5'd6, 32'd0, 32'd5, 32'd5, 32'h204));
    tick();
    drive(0, 1'b0, '0, '0, 1'b0);
    tick();

    // No forwarding: ADD r5 then ADD r6,r5,r1 stalls through ID/EXE and EXE/MEM
    issue(1, rtype(6'd1, 5'd2, 5'd3, 5'd5), 32'h300,
          mk(4'd0, 0, 0, 1, 2'd0, 5'd2, 5'd3, 5'd5, 32'd0, 32'd7, 32'd7, 32'h300));
    drive(1, 1'b1, rtype(6'd1, 5'd5, 5'd1, 5'd6), 32'h304, 1'b0);
    #1;
    check_stall(1, 1'b1, "raw_idex_stall");
    tick();
    mem_dest = 5'd5; mem_wb_en = 1'b1;
    #1;
    check_stall(1, 1'b1, "raw_exmem_stall");
    tick();
    mem_wb_en = 1'b0;
    #1;
    check_stall(1, 1'b0, "raw_clear");
    q1.push_back(mk(4'd0, 0, 0, 1, 2'd0, 5'd5, 5'd1, 5'd6, 32'd0, 32'd5, 32'd5, 32'h304));
    tick();
    drive(1, 1'b0, '0, '0, 1'b0);

    // Same pair with forwarding: never stalls
    issue(0, rtype(6'd1, 5'd2, 5'd3, 5'd5), 32'h300,
          mk(4'd0, 0, 0, 1, 2'd0, 5'd2, 5'd3, 5'd5, 32'd0, 32'd7, 32'd7, 32'h300));
    mem_dest = 5'd5; mem_wb_en = 1'b1;
    issue(0, rtype(6'd1, 5'd5, 5'd1, 5'd6), 32'h304,
          mk(4'd0, 0, 0, 1, 2'd0, 5'd5, 5'd1, 5'd6, 32'd0, 32'd5, 32'd5, 32'h304));
    mem_wb_en = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0);
    tick();

    // Write-first bypass, then r0 ignores a same-cycle write
    wb_en = 1'b1; wb_dest = 5'd9; wb_data = 32'hABCD;
    issue(0, rtype(6'd1, 5'd9, 5'd9, 5'd1), 32'h400,
          mk(4'd0, 0, 0, 1, 2'd0, 5'd9, 5'd9, 5'd1, 32'hABCD, 32'hABCD, 32'hABCD, 32'h400));
    wb_dest = 5'd0; wb_data = 32'h1234;
    issue(0, rtype(6'd1, 5'd0, 5'd9, 5'd2), 32'h404,
          mk(4'd0, 0, 0, 1, 2'd0, 5'd0, 5'd9, 5'd2, 32'd0, 32'hABCD, 32'hABCD, 32'h404));
    wb_en = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0);
    tick();

    // Flush beats a load-use stall
    issue(0, itype(6'd36, 5'd0, 5'd7, 16'd0), 32'h500,
          mk(4'd0, 1, 0, 1, 2'd0, 5'd0, 5'd7, 5'd7, 32'd0, 32'd0, 32'd0, 32'h500));
    drive(0, 1'b1, rtype(6'd1, 5'd7, 5'd7, 5'd8), 32'h504, 1'b1);
    #1;
    check_stall(0, 1'b0, "flush_priority");
    tick();
    check("flush_bubble", 160'(if0.out_valid), 160'(0));
    drive(0, 1'b0, '0, '0, 1'b0);
    tick();

    // Reset in the middle of a load-use stall
    issue(0, itype(6'd36, 5'd0, 5'd7, 16'd0), 32'h600,
          mk(4'd0, 1, 0, 1, 2'd0, 5'd0, 5'd7, 5'd7, 32'd0, 32'd0, 32'd0, 32'h600));
    drive(0, 1'b1, rtype(6'd1, 5'd7, 5'd3, 5'd8), 32'h604, 1'b0);
    #1;
    check_stall(0, 1'b1, "pre_reset_stall");
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("reset_mid_outputs", {act(0), if0.out_valid}, '0);
    check_stall(0, 1'b0, "reset_mid_stall");
    reset = 1'b0;
    #1;
    check_stall(0, 1'b0, "post_reset_stall");
    q0.push_back(mk(4'd0, 0, 0, 1, 2'd0, 5'd7, 5'd3, 5'd8, 32'd0, 32'd0, 32'd0, 32'h604));
    tick();
    drive(0, 1'b0, '0, '0, 1'b0);

    repeat (3) tick();
    check("q0_drained", 160'(q0.size()), 160'(0));
    check("q1_drained", 160'(q1.size()), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_decode_pipe.md
ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter REG_AW, default 5, register address width; register count 2**REG_AW.
REQ-003 Parameter FORWARD_EN, default 1: 1 = only load-use stalls; 0 = stall on any RAW against ID/EXE or EXE/MEM destinations.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 in_valid, instruction[31:0], pc[XLEN-1:0]  input  from IF.
REQ-007 flush  input  1  branch taken; kill the instruction in decode.
REQ-008 wb_en, wb_dest[REG_AW-1:0], wb_data[XLEN-1:0]  input  writeback port.
REQ-009 mem_dest[REG_AW-1:0], mem_wb_en  input  1  EXE/MEM destination; used only when FORWARD_EN=0.
REQ-010 stall  output  1  combinational; IF holds pc/instruction.
REQ-011 Registered outputs: out_valid, exe_cmd[3:0], mem_read, mem_write, wb_en_out, br_type[1:0], src1_addr, src2_addr, dest[REG_AW-1:0], val1, val2, st_val[XLEN-1:0], pc_out.

Function
REQ-012 Opcode instruction[31:26]; src1 = [25:21], src2 = [20:16]; dest = [15:11] for R-type and [20:16] for immediate.
REQ-013 Immediate instructions SHALL give val2 = sign-extended instruction[15:0] to XLEN; R-type SHALL give val2 = reg[src2].
REQ-014 st_val SHALL always equal reg[src2].
REQ-015 Opcodes from package: NOP=0, ADD=1, SUB=2, AND=5, ADDI=32, LD=36, ST=37, BEZ=40, BNE=41, JMP=42.
REQ-016 Unknown opcodes SHALL decode as NOP: all control zero, out_valid=1.
REQ-017 Latency: decode result SHALL appear on registered outputs one cycle after in_valid is accepted.
REQ-018 Register file: 2**REG_AW x XLEN, two combinational reads, one write on the rising edge; register 0 SHALL read 0 and ignore writes.
REQ-019 Write-first bypass: when wb_en=1 and wb_dest equals a nonzero read address in the same cycle, the read SHALL return wb_data.
REQ-020 src2 is "used" for R-type, ST and BNE. src1 is "used" for all opcodes except NOP and JMP.
REQ-021 FORWARD_EN=1: stall=1 when in_valid, the ID/EXE register holds out_valid & mem_read, its dest is nonzero, and dest equals a used source.
REQ-022 FORWARD_EN=0: stall=1 on match of any used nonzero source against ID/EXE dest with wb_en_out, or against mem_dest with mem_wb_en.
REQ-023 On stall, the registered outputs SHALL load a bubble (out_valid=0, all control zero) and IF SHALL retain the instruction.
REQ-024 flush SHALL take priority over stall: load a bubble and deassert stall the same cycle.
REQ-025 in_valid=0 SHALL load a bubble; stall SHALL be 0.
REQ-026 A bubble SHALL clear val1, val2 and st_val to zero.

Reset
REQ-027 Asynchronous reset SHALL zero every registered output (out_valid=0) and every register-file entry.
REQ-028 Reset asserted mid-stall SHALL clear the pending hazard; the first cycle after release SHALL decode in_valid fresh.

Structure
REQ-029 Package id_pkg SHALL hold the opcode constants, exe_cmd encodings (ADD=0, SUB=2, AND=4, ...) and br_type encodings (NONE=0, BEZ=1, BNE=2, JMP=3).
REQ-030 One sub-module, hazard_detect, SHALL hold the combinational stall logic for both FORWARD_EN modes; the register file SHALL be inline.

Verification
REQ-031 Write reg3=7 via WB, then ADDI r4,r3,-1 -> next cycle val1=7, val2=0xFFFFFFFF, dest=4, wb_en_out=1.
REQ-032 LD r5 followed by ADD r6,r5,r1 with FORWARD_EN=1 -> stall=1 for one cycle, one bubble, then ADD issues with src1_addr=5.
REQ-033 Same ADD sequence after an ADD r5 with FORWARD_EN=0 -> stall while r5 is in ID/EXE, then while r5 is in EXE/MEM (mem_wb_en=1); no stall with FORWARD_EN=1.
REQ-034 wb_en=1, wb_dest=9, wb_data=0xABCD while decoding ADD r1,r9,r9 -> val1=val2=0xABCD (bypass); wb_dest=0 -> val1=0.
REQ-035 flush=1 together with a load-use stall -> stall=0, out_valid=0 next cycle.
REQ-036 Assert reset during a stall -> all outputs 0 immediately; after release, the held instruction decodes with no stall.
